// File: rtl/sqrl_interrupt_queue.sv
// Per-source interrupt event queue: FIFO of 64-bit events presented as a level request to the arbiter.
// Optional ASSERT timeout/retry is enabled by defining SQRL_IRQ_TIMEOUT_EN.
module sqrl_interrupt_queue #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ev_push,
  input  logic [63:0]              i_ev_data,
  output logic                     o_ev_full,
  output logic                     o_interrupt,
  output logic [63:0]              o_interrupt_data,
  input  logic                     i_interrupt_ack,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_drop_count,
  output logic [15:0]              o_retry_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP + 1);

  // state  | meaning
  // IDLE   | queue empty, interrupt low
  // ASSERT | interrupt high with head entry, waiting for ack
  // GAP    | interrupt low for GAP cycles after ack or retry
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

  state_t          r_state;
  logic            r_irq;
  logic [63:0]     r_head;
  logic [63:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_full;
  logic [15:0]     r_drop_count;
  logic [GW-1:0]   r_gap_cnt;

  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;
  logic            w_timeout;
  logic [AW-1:0]   w_rptr_nxt;
  logic [LW-1:0]   w_level_nxt;

  assign w_pop      = (r_state == S_ASSERT) && i_interrupt_ack;
  // A push into a full queue still lands when the head pops on the same edge.
  assign w_push_ok  = i_ev_push && (!r_full || w_pop);
  assign w_drop     = i_ev_push && r_full && !w_pop;
  assign w_rptr_nxt = r_rptr + AW'(1);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_ok, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

`ifdef SQRL_IRQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] r_to_cnt;
  logic [15:0]   r_retry_count;

  assign w_timeout = (r_to_cnt == '0);

  // Reloaded whenever outside ASSERT so every entry into ASSERT starts a full window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt      <= '0;
      r_retry_count <= '0;
    end else begin
      if (r_state != S_ASSERT)
        r_to_cnt <= TW'(TIMEOUT - 1);
      else if (r_to_cnt != '0)
        r_to_cnt <= r_to_cnt - TW'(1);
      if ((r_state == S_ASSERT) && w_timeout && !i_interrupt_ack && (r_retry_count != 16'hFFFF))
        r_retry_count <= r_retry_count + 16'd1;
    end
  end

  assign o_retry_count = r_retry_count;
`else
  assign w_timeout     = 1'b0;
  assign o_retry_count = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (w_push_ok)
      r_mem[r_wptr] <= i_ev_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_full       <= 1'b0;
      r_drop_count <= '0;
      r_head       <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      if (w_push_ok)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= w_rptr_nxt;
      if (w_drop && (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;
      // Head register: next stored entry, or the bypassed push when it is the only one left.
      if (w_pop) begin
        if (r_level > LW'(1))
          r_head <= r_mem[w_rptr_nxt];
        else if (w_push_ok)
          r_head <= i_ev_data;
      end else if (w_push_ok && (r_level == '0)) begin
        r_head <= i_ev_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_irq     <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_level != '0) begin
            r_state <= S_ASSERT;
            r_irq   <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (i_interrupt_ack || w_timeout) begin
            r_state   <= S_GAP;
            r_irq     <= 1'b0;
            r_gap_cnt <= GW'(GAP);
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            if (r_level != '0) begin
              r_state <= S_ASSERT;
              r_irq   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign o_interrupt      = r_irq;
  assign o_interrupt_data = r_head;
  assign o_ev_full        = r_full;
  assign o_level          = r_level;
  assign o_drop_count     = r_drop_count;

endmodule

// File: tb/tb_sqrl_interrupt_queue.sv
// Scoreboard bench for sqrl_interrupt_queue; define SQRL_IRQ_TIMEOUT_EN to exercise the retry path.
module tb_sqrl_interrupt_queue;

  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ev_push = 1'b0;
  logic [63:0]            ev_data = '0;
  logic                   ack = 1'b0;
  logic                   ev_full;
  logic                   irq;
  logic [63:0]            irq_data;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]            drop_count;
  logic [15:0]            retry_count;

  logic [63:0] sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int drops_exp = 0;

  sqrl_interrupt_queue #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_ev_push(ev_push), .i_ev_data(ev_data),
    .o_ev_full(ev_full), .o_interrupt(irq), .o_interrupt_data(irq_data),
    .i_interrupt_ack(ack), .o_level(level), .o_drop_count(drop_count),
    .o_retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [63:0] d);
    if (sb.size() < DEPTH) sb.push_back(d);
    else drops_exp++;
    ev_push = 1'b1;
    ev_data = d;
    tick();
    ev_push = 1'b0;
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!irq && n < 100) begin
      tick();
      n++;
    end
    check("irq_wait", 64'(irq), 64'd1);
  endtask

  task automatic ack_one();
    wait_irq();
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      check("ack_data", irq_data, sb.pop_front());
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("irq_drop", 64'(irq), 64'd0);
      check("level_after_ack", 64'(level), 64'(sb.size()));
    end
  endtask

  task automatic ack_gap();
    int low = 0;
    ack_one();
    if (sb.size() > 0) begin
      while (!irq && low < 50) begin
        low++;
        tick();
      end
      check("gap_low", 64'(low), 64'(GAP + 1));
    end
  endtask

  initial begin
    logic [63:0] d;
    int hi;

    repeat (2) tick();
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_data", irq_data, 64'd0);
    check("rst_full", 64'(ev_full), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_retry", 64'(retry_count), 64'd0);
    rst = 1'b0;
    tick();

    // single event latency
    push_ev(64'hDEAD_BEEF_0000_0001);
    check("lat_level", 64'(level), 64'd1);
    check("lat_irq_low", 64'(irq), 64'd0);
    tick();
    check("lat_irq_high", 64'(irq), 64'd1);
    check("lat_data", irq_data, 64'hDEAD_BEEF_0000_0001);
    ack_one();
    repeat (GAP + 3) tick();

    // fill, overflow, ordered drain
    for (int i = 0; i < DEPTH; i++) push_ev(64'h1000 + 64'(i));
    check("fill_full", 64'(ev_full), 64'd1);
    check("fill_level", 64'(level), 64'(DEPTH));
    push_ev(64'h1FFF);
    check("ovf_drop", 64'(drop_count), 64'(drops_exp));
    check("ovf_level", 64'(level), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) ack_gap();
    check("drain_full", 64'(ev_full), 64'd0);
    repeat (GAP + 3) tick();

    // push and pop on the same edge while full
    for (int i = 0; i < DEPTH; i++) push_ev(64'h2000 + 64'(i));
    wait_irq();
    check("pp_head", irq_data, sb.pop_front());
    sb.push_back(64'h2ABC);
    ev_push = 1'b1;
    ev_data = 64'h2ABC;
    ack = 1'b1;
    tick();
    ev_push = 1'b0;
    ack = 1'b0;
    check("pp_level", 64'(level), 64'(DEPTH));
    check("pp_full", 64'(ev_full), 64'd1);
    check("pp_drop", 64'(drop_count), 64'(drops_exp));
    for (int i = 0; i < DEPTH; i++) ack_gap();
    repeat (GAP + 3) tick();

    // acks in IDLE and GAP are ignored
    push_ev(64'h3000);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_level", 64'(level), 64'd1);
    check("idle_ack_irq", 64'(irq), 64'd1);
    push_ev(64'h3001);
    ack_one();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("gap_ack_level", 64'(level), 64'd1);
    check("gap_ack_irq", 64'(irq), 64'd0);
    ack_one();
    repeat (GAP + 3) tick();

`ifdef SQRL_IRQ_TIMEOUT_EN
    push_ev(64'h4000);
    wait_irq();
    hi = 0;
    while (irq && hi < 50) begin
      hi++;
      tick();
    end
    check("to_high_cycles", 64'(hi), 64'(TIMEOUT));
    check("to_retry", 64'(retry_count), 64'd1);
    check("to_level", 64'(level), 64'd1);
    wait_irq();
    check("to_reassert_data", irq_data, sb[0]);
    repeat (TIMEOUT - 1) tick();
    check("to_still_high", 64'(irq), 64'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    d = sb.pop_front();
    check("to_ack_irq", 64'(irq), 64'd0);
    check("to_ack_level", 64'(level), 64'd0);
    check("to_ack_retry", 64'(retry_count), 64'd1);
`else
    push_ev(64'h4000);
    wait_irq();
    repeat (20) tick();
    check("hold_irq", 64'(irq), 64'd1);
    check("hold_retry", 64'(retry_count), 64'd0);
    check("hold_data", irq_data, 64'h4000);
    ack_one();
`endif
    repeat (GAP + 3) tick();

    // reset mid-operation
    push_ev(64'h5000);
    push_ev(64'h5001);
    push_ev(64'h5002);
    wait_irq();
    check("prerst_level", 64'(level), 64'd3);
    rst = 1'b1;
    ack = 1'b1;
    tick();
    rst = 1'b0;
    ack = 1'b0;
    sb.delete();
    drops_exp = 0;
    check("mrst_irq", 64'(irq), 64'd0);
    check("mrst_level", 64'(level), 64'd0);
    check("mrst_drop", 64'(drop_count), 64'd0);
    check("mrst_retry", 64'(retry_count), 64'd0);
    check("mrst_full", 64'(ev_full), 64'd0);
    check("mrst_data", irq_data, 64'd0);
    tick();
    push_ev(64'h6000_0000_CAFE_F00D);
    ack_one();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrl_interrupt_queue.md
# sqrl_interrupt_queue

Per-source interrupt event queue upstream of the interrupt arbiter. It buffers 64-bit interrupt events from a producer in a small FIFO and presents the head entry as a level interrupt plus data to one arbiter input (A or B). It holds the request until the arbiter returns an ack, then pops the entry and re-arms after a fixed gap. Without acks it can optionally retry.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- GAP, 2, cycles interrupt stays low after an ack or retry before re-asserting; ≥1
- TIMEOUT, 1024, cycles in ASSERT without ack before a retry; ≥4; used only with SQRL_IRQ_TIMEOUT_EN
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- evPush  in  1  one-cycle strobe: enqueue evData
- evData  in  64  event payload
- evFull  out  1  FIFO holds DEPTH entries (registered)
- interrupt  out  1  request to arbiter (interruptA/interruptB); registered
- interruptData  out  64  head-entry payload; stable while interrupt=1
- interruptAck  in  1  ack from arbiter (interruptAckA/interruptAckB)
- level  out  clog2(DEPTH)+1  current FIFO occupancy
- dropCount  out  16  saturating count of pushes lost while full
- retryCount  out  16  saturating count of timeout retries; constant 0 without SQRL_IRQ_TIMEOUT_EN

## Operation
- FIFO: circular buffer with wrapping read/write pointers; level = entries held; evFull = (level==DEPTH).
- Push when not full: write at wptr, level+1. Push when full, no pop the same edge: entry dropped, dropCount+1, saturates at 0xFFFF.
- Push and pop on the same edge: both take effect and level is unchanged. This also holds when full; the push is not dropped.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: interrupt=0. If level>0 → ASSERT.
  - ASSERT: interrupt=1, interruptData=head. interruptAck=1 → pop, go to GAP.
  - GAP: interrupt=0. Counts GAP cycles, then → ASSERT if level>0 at that moment, else → IDLE.
- Ack sampled in IDLE or GAP: ignored; no pop.
- interruptData is the registered head value. It changes only on a pop or a push into an empty FIFO, and never while interrupt=1.
- The arbiter selects combinationally on interrupt, so interrupt must never drop in ASSERT before an ack, except by a timeout retry.

## Timing
- Reset: interrupt=0, interruptData=0, evFull=0, level=0, dropCount=0, retryCount=0; FSM=IDLE; pointers=0.
- rst mid-operation: at the next edge the FIFO is flushed, the FSM goes to IDLE and interrupt=0. A pending ack is discarded.
- Latency, push to interrupt: push sampled at edge N into an empty queue in IDLE gives level=1 after N and interrupt=1 after N+1.
- Ack: interruptAck sampled at edge M in ASSERT gives interrupt=0 and pop after M. The earliest re-assert is after edge M+GAP+1.
- Back-to-back events are therefore separated by ≥GAP low cycles.
- evFull and level update on the same edge as the push or pop.

## Configuration
- SQRL_IRQ_TIMEOUT_EN defined:
  - A counter clears on entry to ASSERT.
  - After TIMEOUT cycles in ASSERT with no ack, the FSM goes to GAP without popping and retryCount+1 (saturating). The same entry is then re-asserted.
  - Ack on the timeout cycle: ack wins; pop, no retry count.
- Undefined: no counter logic; ASSERT waits indefinitely; retryCount tied to 0.

## Test plan
- Reset then single push of 0xDEAD_BEEF_0000_0001 at edge N → interrupt=1 after N+1 with that data. Ack one cycle later → interrupt=0 and level=0.
- Push 4 events (DEPTH=4), then a 5th while full → evFull=1, dropCount=1. Acks deliver data in push order, each separated by ≥2 low cycles.
- Full queue with push and ack on the same edge → level stays 4, dropCount unchanged, new entry delivered last.
- Ack pulses while in IDLE and during GAP → no pop, level unchanged.
- With SQRL_IRQ_TIMEOUT_EN and TIMEOUT=8: hold ack low → interrupt drops after 8 cycles, retryCount=1, same data re-asserted after GAP. Ack on the timeout cycle → pop, retryCount unchanged.
- rst asserted while interrupt=1 with level=3 → after the next edge interrupt=0, level=0, counters=0. A push after rst is released is delivered normally.
